// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer slice.
//   seq_state_e : sequencer FSM states
//   CAUSE_*     : encodings reported on rst_cause
//   max_int     : elaboration-time helper used to size the stage counter
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        REL_CORE,
        REL_ADC,
        REL_UDP,
        RUN
    } seq_state_e;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;
    localparam logic [1:0] CAUSE_WDT  = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : async active-low clear (both flops go to 0)
//   d     : asynchronous input
//   q     : synchronized output, two clk edges of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: holds core/adc/udp resets low for HOLD_CYC cycles,
// waits for PLL lock, then releases core, adc, udp STAGE_DLY cycles apart and
// raises seq_done. Lock loss, soft request (and optionally the watchdog)
// drop every reset and restart from HOLD, recording the cause.
//
// Optional feature: define RST_SEQ_WDT_EN to build the RUN-state watchdog.
//
// Ports:
//   clk, rst_n        : system clock, async active-low power-on reset
//   pll_locked        : async PLL lock (synchronized internally)
//   soft_rst_req      : one-cycle soft reset request (REL_* / RUN only)
//   wdt_kick          : watchdog kick (unused without RST_SEQ_WDT_EN)
//   rst_n_core/adc/udp: registered active-low stage resets
//   seq_done          : high in RUN
//   rst_cause         : last reset cause (rst_seq_pkg CAUSE_*)
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_DLY = 16,
    parameter int WDT_CYC   = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    input  logic       wdt_kick,
    output logic       rst_n_core,
    output logic       rst_n_adc,
    output logic       rst_n_udp,
    output logic       seq_done,
    output logic [1:0] rst_cause
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYC, STAGE_DLY) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);

    seq_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             in_rel;
    logic             wdt_fire;
    logic             fault;
    logic [1:0]       fault_cause;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Faults are only honoured once release has started.
    assign in_rel = state inside {REL_CORE, REL_ADC, REL_UDP, RUN};

`ifdef RST_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYC + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);

    logic [WDT_W-1:0] wdt_cnt;

    // A kick on the terminal cycle wins over the timeout.
    assign wdt_fire = (state == RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
        end else if (state != RUN || wdt_kick || fault) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    logic unused_wdt_kick;
    localparam int unused_wdt_cyc = WDT_CYC;

    assign unused_wdt_kick = wdt_kick;
    assign wdt_fire        = 1'b0;
`endif

    // Priority: lock loss > watchdog > soft request.
    always_comb begin
        fault       = 1'b0;
        fault_cause = CAUSE_LOCK;
        if (in_rel) begin
            if (!lock_s) begin
                fault       = 1'b1;
                fault_cause = CAUSE_LOCK;
            end else if (wdt_fire) begin
                fault       = 1'b1;
                fault_cause = CAUSE_WDT;
            end else if (soft_rst_req) begin
                fault       = 1'b1;
                fault_cause = CAUSE_SOFT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HOLD;
            cnt        <= '0;
            rst_n_core <= 1'b0;
            rst_n_adc  <= 1'b0;
            rst_n_udp  <= 1'b0;
            seq_done   <= 1'b0;
            rst_cause  <= CAUSE_POR;
        end else if (fault) begin
            state      <= HOLD;
            cnt        <= '0;
            rst_n_core <= 1'b0;
            rst_n_adc  <= 1'b0;
            rst_n_udp  <= 1'b0;
            seq_done   <= 1'b0;
            rst_cause  <= fault_cause;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state      <= REL_CORE;
                        cnt        <= '0;
                        rst_n_core <= 1'b1;
                    end
                end
                REL_CORE: begin
                    if (cnt == STAGE_LAST) begin
                        state     <= REL_ADC;
                        cnt       <= '0;
                        rst_n_adc <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REL_ADC: begin
                    if (cnt == STAGE_LAST) begin
                        state     <= REL_UDP;
                        cnt       <= '0;
                        rst_n_udp <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REL_UDP: begin
                    if (cnt == STAGE_LAST) begin
                        state    <= RUN;
                        cnt      <= '0;
                        seq_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    cnt <= '0;
                end
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
